// File: rtl/seq_alu.sv
// seq_alu: multi-cycle RV32I execute unit with valid/ready handshakes and bit-serial shifts.
// Optional shift-add multiplier (op 1010) is compiled in when SEQ_ALU_MUL_EN is defined.
module seq_alu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);
    localparam int unsigned CNT_W   = SHAMT_W + 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b1001;
`ifdef SEQ_ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1010;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_MUL,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [3:0]        op_q;
    logic [XLEN-1:0]   work_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   result_q;
    logic              zero_q;
    logic              out_valid_q;

    logic [XLEN-1:0]   alu_d;
    logic [XLEN-1:0]   shift_d;
    logic              is_shift_c;
    logic [SHAMT_W-1:0] shamt_c;

`ifdef SEQ_ALU_MUL_EN
    logic [XLEN-1:0]   mplier_q;
    logic [XLEN-1:0]   acc_q;
    logic [XLEN-1:0]   mul_step_d;
    logic              is_mul_c;

    assign is_mul_c   = (alu_ctrl == OP_MUL);
    // work_q holds the multiplicand while in S_MUL
    assign mul_step_d = acc_q + (mplier_q[0] ? work_q : '0);
`endif

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign zero       = zero_q;
    assign shamt_c    = src_b[SHAMT_W-1:0];
    assign is_shift_c = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);

    // Single-cycle result; unlisted codes (and MUL when absent) behave as ADD
    always_comb begin
        alu_d = src_a + src_b;
        case (alu_ctrl)
            OP_SUB:  alu_d = src_a - src_b;
            OP_SLT:  alu_d = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: alu_d = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            OP_XOR:  alu_d = src_a ^ src_b;
            OP_OR:   alu_d = src_a | src_b;
            OP_AND:  alu_d = src_a & src_b;
            default: alu_d = src_a + src_b;
        endcase
    end

    // One-bit shift step; direction comes from the latched op
    always_comb begin
        shift_d = {work_q[XLEN-2:0], 1'b0};
        case (op_q)
            OP_SRL:  shift_d = {1'b0, work_q[XLEN-1:1]};
            OP_SRA:  shift_d = {work_q[XLEN-1], work_q[XLEN-1:1]};
            default: shift_d = {work_q[XLEN-2:0], 1'b0};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            work_q      <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            mplier_q    <= '0;
            acc_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q <= alu_ctrl;
                        if (is_shift_c) begin
                            work_q <= src_a;
                            cnt_q  <= CNT_W'(shamt_c);
                            if (shamt_c == '0) begin
                                result_q    <= src_a;
                                zero_q      <= (src_a == '0);
                                out_valid_q <= 1'b1;
                                state_q     <= S_DONE;
                            end else begin
                                state_q <= S_SHIFT;
                            end
`ifdef SEQ_ALU_MUL_EN
                        end else if (is_mul_c) begin
                            work_q   <= src_a;
                            mplier_q <= src_b;
                            acc_q    <= '0;
                            cnt_q    <= CNT_W'(XLEN);
                            state_q  <= S_MUL;
`endif
                        end else begin
                            result_q    <= alu_d;
                            zero_q      <= (alu_d == '0);
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    work_q <= shift_d;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        result_q    <= shift_d;
                        zero_q      <= (shift_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_MUL: begin
`ifdef SEQ_ALU_MUL_EN
                    acc_q    <= mul_step_d;
                    work_q   <= {work_q[XLEN-2:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[XLEN-1:1]};
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        result_q    <= mul_step_d;
                        zero_q      <= (mul_step_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
`else
                    state_q <= S_IDLE;
`endif
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu; expected values are hand-computed constants.
// Honours SEQ_ALU_MUL_EN for the MUL expectation.
module tb_seq_alu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_alu dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, count latency in cycles (1 = result right after accept edge), then retire it
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_zero, input int exp_lat);
        int n;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        alu_ctrl = op;
        src_a    = a;
        src_b    = b;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        src_a    = ~a;
        src_b    = ~b;
        alu_ctrl = 4'b0001;
        n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_zero"}, 32'(zero), 32'(exp_zero));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_retired"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        alu_ctrl  = 4'b0000;
        src_a     = 32'h0;
        src_b     = 32'h0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_zero", 32'(zero), 32'd0);

        run_op("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1);
        run_op("sub_zero", 4'b0001, 32'd5, 32'd5, 32'h0, 1'b1, 1);
        run_op("sra31", 4'b0111, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 32);
        run_op("srl31", 4'b0110, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 32);
        run_op("sll0", 4'b0010, 32'h1234_5678, 32'h20, 32'h1234_5678, 1'b0, 1);
        run_op("sll4", 4'b0010, 32'h0000_0001, 32'd4, 32'h0000_0010, 1'b0, 5);
        run_op("sra3_pos", 4'b0111, 32'h4000_0000, 32'd3, 32'h0800_0000, 1'b0, 4);
        run_op("slt", 4'b0011, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1);
        run_op("sltu", 4'b0100, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1);
        run_op("xor", 4'b0101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1);
        run_op("or", 4'b1000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1);
        run_op("and", 4'b1001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1);
        run_op("undef_f", 4'b1111, 32'd3, 32'd4, 32'd7, 1'b0, 1);
`ifdef SEQ_ALU_MUL_EN
        run_op("mul", 4'b1010, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b0, 33);
`else
        run_op("mul_as_add", 4'b1010, 32'hFFFF_FFFF, 32'd3, 32'h0000_0002, 1'b0, 1);
`endif

        // Back-pressure: hold result for 5 cycles while a competing request is offered
        @(negedge clk);
        in_valid = 1'b1;
        alu_ctrl = 4'b0000;
        src_a    = 32'd10;
        src_b    = 32'd20;
        @(negedge clk);
        alu_ctrl = 4'b0001;
        src_a    = 32'd1;
        src_b    = 32'd1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_result", result, 32'd30);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_retired", 32'(out_valid), 32'd0);
        chk("bp_idle", 32'(in_ready), 32'd1);
        chk("bp_result_kept", result, 32'd30);

        // Reset in the middle of a 31-bit SLL
        @(negedge clk);
        in_valid = 1'b1;
        alu_ctrl = 4'b0010;
        src_a    = 32'h0000_0001;
        src_b    = 32'd31;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_shift_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", result, 32'h0);
        repeat (40) @(negedge clk);
        chk("mid_rst_no_late", 32'(out_valid), 32'd0);
        run_op("add_after_rst", 4'b0000, 32'd2, 32'd2, 32'd4, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
